hatch_ctrl: RTL

Incubation sequencer for the egg-hatch dot-matrix demo. It runs on the 1 kHz system clock and takes the start/stop keys and the temperature switch. It produces the display stage index num (0..11), the enable st and the temperature-warning flag temp. The dot-matrix display stage sits directly downstream and renders the egg/chick picture for num. It overlays red on the picture when temp=1 and blanks when st=0.

---
 rtl/hatch_pkg.sv | 23 ++
 rtl/hatch_ctrl_sync_edge.sv | 36 +++
 rtl/hatch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hatch_pkg.sv
// Shared definitions for the egg-hatch sequencer and the dot-matrix stage
// renderer: FSM states and the named stage-index ranges.
package hatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int NUM_STAGES = 12;

    // Picture groups the display selects on; indices are inclusive ranges.
    localparam logic [3:0] STAGE_EGG_FIRST   = 4'd0;
    localparam logic [3:0] STAGE_EGG_LAST    = 4'd4;
    localparam logic [3:0] STAGE_FULL        = 4'd5;
    localparam logic [3:0] STAGE_CRACK_FIRST = 4'd6;
    localparam logic [3:0] STAGE_CRACK_LAST  = 4'd7;
    localparam logic [3:0] STAGE_CHICK_FIRST = 4'd8;
    localparam logic [3:0] STAGE_CHICK_LAST  = 4'd11;

endpackage

// File: rtl/hatch_ctrl_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse on
// each synchronised rising edge (a held input yields a single pulse).
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl   = sync_q;
    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/hatch_ctrl.sv
// Incubation sequencer: steps the display stage index once every STAGE_SEC
// seconds while running, freezes on a temperature fault, stops on request.
module hatch_ctrl
    import hatch_pkg::*;
#(
    parameter int CLK_HZ     = 1000,
    parameter int STAGE_SEC  = 3,
    parameter int LAST_STAGE = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       temp_sw,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic       done,
    output logic [3:0] sec_cnt
);

    localparam int             PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]     SEC_MAX = 4'(STAGE_SEC - 1);
    localparam logic [3:0]     NUM_MAX = 4'(LAST_STAGE);

    logic start_p, stop_p, temp_s;
    logic start_lvl, stop_lvl, temp_pulse;
    logic unused_sync;

    sync_edge u_sync_start (.clk(clk), .rst(rst), .d(key_start), .lvl(start_lvl),  .pulse(start_p));
    sync_edge u_sync_stop  (.clk(clk), .rst(rst), .d(key_stop),  .lvl(stop_lvl),   .pulse(stop_p));
    sync_edge u_sync_temp  (.clk(clk), .rst(rst), .d(temp_sw),   .lvl(temp_s),     .pulse(temp_pulse));

    assign unused_sync = start_lvl | stop_lvl | temp_pulse;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    sec_cnt_q, sec_cnt_d;
    logic [3:0]    num_q, num_d;
    logic          temp_q, temp_d;
    logic          count_en;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sec_cnt_d = sec_cnt_q;
        num_d     = num_q;
        count_en  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_p) begin
                    state_d   = RUN;
                    pre_d     = '0;
                    sec_cnt_d = '0;
                    num_d     = '0;
                end
            end
            RUN: begin
                if (temp_s) state_d = HOLD;
                else        count_en = 1'b1;
            end
            HOLD: begin
                // The edge that sees the fault clear already counts, so a
                // fault seen for N edges delays the sequence by exactly N.
                if (!temp_s) begin
                    state_d  = RUN;
                    count_en = 1'b1;
                end
            end
        endcase

        if (count_en) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (sec_cnt_q == SEC_MAX) begin
                    sec_cnt_d = '0;
                    if (num_q == NUM_MAX) state_d = DONE;
                    else                  num_d   = num_q + 4'd1;
                end else begin
                    sec_cnt_d = sec_cnt_q + 4'd1;
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        if (stop_p) begin
            state_d   = IDLE;
            pre_d     = '0;
            sec_cnt_d = '0;
            num_d     = '0;
        end

        temp_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            sec_cnt_q <= '0;
            num_q     <= '0;
            temp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sec_cnt_q <= sec_cnt_d;
            num_q     <= num_d;
            temp_q    <= temp_d;
        end
    end

    assign num     = num_q;
    assign sec_cnt = sec_cnt_q;
    assign temp    = temp_q;
    assign st      = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
